// File: rtl/instr_fetch.sv
// Instruction-fetch responder: reads opcode/arg1/arg2 as three consecutive bytes
// from 1-cycle-latency program memory and presents them with a valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for fetch_req
// ISSUE | three read cycles at pc, pc+1, pc+2 (cnt = byte index)
// DRAIN | no read; last byte returning from memory is captured
// VALID | instruction held on op_code/arg1/arg2 until transferred
module instr_fetch #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_pc,
    input  logic              flush,
    output logic              busy,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [7:0]        op_code,
    output logic [7:0]        arg1,
    output logic [7:0]        arg2
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] VALID = 2'd3;

    logic [1:0]        state;
    logic [1:0]        cnt;
    logic [ADDR_W-1:0] pc;
    logic              start;

    assign start       = fetch_req && ((state == IDLE) || ((state == VALID) && instr_ready));
    assign busy        = (state == ISSUE) || (state == DRAIN);
    assign instr_valid = (state == VALID);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= 2'd0;
            pc       <= '0;
            mem_rd   <= 1'b0;
            mem_addr <= '0;
            op_code  <= 8'h00;
            arg1     <= 8'h00;
            arg2     <= 8'h00;
        end else if (flush) begin
            // Abort wins over everything; the last delivered instruction bytes stay visible.
            state  <= IDLE;
            cnt    <= 2'd0;
            mem_rd <= 1'b0;
        end else begin
            case (state)
                IDLE, VALID: begin
                    if (start) begin
                        pc       <= fetch_pc;
                        cnt      <= 2'd0;
                        mem_rd   <= 1'b1;
                        mem_addr <= fetch_pc;
                        state    <= ISSUE;
                    end else if ((state == VALID) && instr_ready) begin
                        state <= IDLE;
                    end
                end
                ISSUE: begin
                    // Data for the address issued in the previous cycle is on mem_rdata now.
                    case (cnt)
                        2'd1:    op_code <= mem_rdata;
                        2'd2:    arg1    <= mem_rdata;
                        default: ;
                    endcase
                    if (cnt == 2'd2) begin
                        mem_rd <= 1'b0;
                        state  <= DRAIN;
                    end else begin
                        cnt      <= cnt + 2'd1;
                        mem_addr <= pc + ADDR_W'(cnt + 2'd1);
                    end
                end
                DRAIN: begin
                    arg2  <= mem_rdata;
                    state <= VALID;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: behavioural program memory, address and
// instruction scoreboards, latency/backpressure/flush/reset scenarios.
module tb_instr_fetch;

    typedef struct packed {
        logic [7:0] op;
        logic [7:0] a1;
        logic [7:0] a2;
    } instr_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       fetch_req;
    logic [7:0] fetch_pc;
    logic       flush;
    logic       busy;
    logic       mem_rd;
    logic [7:0] mem_addr;
    logic [7:0] mem_rdata;
    logic       instr_valid;
    logic       instr_ready;
    logic [7:0] op_code;
    logic [7:0] arg1;
    logic [7:0] arg2;

    logic [7:0] mem [256];
    instr_t     exp_q [$];
    logic [7:0] addr_q [$];
    instr_t     cur;
    instr_t     last;
    int         n_chk = 0;
    int         n_err = 0;

    instr_fetch #(.ADDR_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_req   (fetch_req),
        .fetch_pc    (fetch_pc),
        .flush       (flush),
        .busy        (busy),
        .mem_rd      (mem_rd),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .op_code     (op_code),
        .arg1        (arg1),
        .arg2        (arg2)
    );

    always #5 clk = ~clk;

    // Synchronous program memory, 1-cycle read latency.
    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // Outputs and inputs are sampled mid-cycle; inputs change 2 time units after posedge.
    always @(negedge clk) begin : monitor
        instr_t e;
        if (rst_n) begin
            if (mem_rd) begin
                chk("rd_in_issue", busy, 1);
                if (addr_q.size() == 0) chk("rd_unexpected", addr_q.size(), 1);
                else chk("mem_addr", mem_addr, addr_q.pop_front());
            end
            if (instr_valid && instr_ready && !flush) begin
                if (exp_q.size() == 0) chk("xfer_unexpected", exp_q.size(), 1);
                else begin
                    e = exp_q.pop_front();
                    chk("op_code", op_code, e.op);
                    chk("arg1", arg1, e.a1);
                    chk("arg2", arg2, e.a2);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_exp(input logic [7:0] pc);
        logic [7:0] p;
        p = pc;
        cur = '{mem[p], mem[p + 8'd1], mem[p + 8'd2]};
        exp_q.push_back(cur);
        addr_q.push_back(p);
        addr_q.push_back(p + 8'd1);
        addr_q.push_back(p + 8'd2);
    endtask

    // Called just after the request edge E0; checks busy window and valid at E4.
    task automatic lat_check();
        chk("e0_busy", busy, 1);
        chk("e0_valid", instr_valid, 0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("lat_valid_lo", instr_valid, 0);
            chk("lat_busy", busy, 1);
        end
        tick();
        chk("lat_valid_hi", instr_valid, 1);
        chk("valid_busy", busy, 0);
        chk("valid_rd", mem_rd, 0);
    endtask

    task automatic fetch(input logic [7:0] pc);
        fetch_req = 1'b1;
        fetch_pc  = pc;
        push_exp(pc);
        tick();
        fetch_req = 1'b0;
        lat_check();
    endtask

    task automatic accept();
        last = exp_q.size() > 0 ? exp_q[0] : cur;
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        chk("post_xfer_valid", instr_valid, 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[8'h10] = 8'hA0; mem[8'h11] = 8'h01; mem[8'h12] = 8'h02;
        mem[8'h13] = 8'hB1; mem[8'h14] = 8'hB2; mem[8'h15] = 8'hB3;
        mem[8'hFE] = 8'h11; mem[8'hFF] = 8'h22; mem[8'h00] = 8'h33;
        mem[8'h20] = 8'hC0; mem[8'h21] = 8'hC1; mem[8'h22] = 8'hC2;
        last = '0;

        rst_n = 1'b0; fetch_req = 1'b0; fetch_pc = 8'h00; flush = 1'b0; instr_ready = 1'b0;
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_rd", mem_rd, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_instr", {op_code, arg1, arg2}, 0);
        rst_n = 1'b1;
        tick();

        // Basic fetch at 0x10
        fetch(8'h10);
        chk("basic_op", op_code, 8'hA0);
        chk("basic_a1", arg1, 8'h01);
        chk("basic_a2", arg2, 8'h02);
        accept();

        // Address wrap FE, FF, 00
        fetch(8'hFE);
        chk("wrap_instr", {op_code, arg1, arg2}, 24'h112233);
        accept();

        // Backpressure: held outputs, ignored requests, then exactly one transfer
        fetch(8'h40);
        for (int i = 0; i < 5; i++) begin
            fetch_req = 1'b1;
            fetch_pc  = 8'h50;
            tick();
            chk("bp_valid", instr_valid, 1);
            chk("bp_instr", {op_code, arg1, arg2}, cur);
            chk("bp_rd", mem_rd, 0);
            chk("bp_busy", busy, 0);
        end
        fetch_req = 1'b0;
        accept();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_single_valid", instr_valid, 0);
            chk("bp_single_busy", busy, 0);
        end

        // Back-to-back: new request in the transfer cycle restarts with no idle gap
        fetch(8'h10);
        last        = cur;
        instr_ready = 1'b1;
        fetch_req   = 1'b1;
        fetch_pc    = 8'h13;
        push_exp(8'h13);
        tick();
        fetch_req   = 1'b0;
        instr_ready = 1'b0;
        lat_check();
        chk("b2b_instr", {op_code, arg1, arg2}, 24'hB1B2B3);
        accept();

        // Flush in the second ISSUE cycle
        fetch_req = 1'b1;
        fetch_pc  = 8'h60;
        push_exp(8'h60);
        tick();
        fetch_req = 1'b0;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_valid", instr_valid, 0);
        chk("flush_busy", busy, 0);
        chk("flush_rd", mem_rd, 0);
        chk("flush_keep", {op_code, arg1, arg2}, last);
        chk("flush_addr_left", addr_q.size(), 1);
        addr_q.delete();
        void'(exp_q.pop_back());
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("flush_no_valid", instr_valid, 0);
        end
        fetch(8'h20);
        chk("post_flush_instr", {op_code, arg1, arg2}, 24'hC0C1C2);
        accept();

        // Reset in the middle of a fetch (after op_code and arg1 are captured)
        fetch_req = 1'b1;
        fetch_pc  = 8'hFE;
        push_exp(8'hFE);
        tick();
        fetch_req = 1'b0;
        tick(); tick(); tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_rd", mem_rd, 0);
        chk("arst_valid", instr_valid, 0);
        chk("arst_addr", mem_addr, 0);
        chk("arst_instr", {op_code, arg1, arg2}, 0);
        chk("arst_addr_left", addr_q.size(), 0);
        exp_q.delete();
        addr_q.delete();
        tick();
        rst_n = 1'b1;
        tick();
        chk("arst_idle_busy", busy, 0);
        chk("arst_idle_valid", instr_valid, 0);
        fetch(8'h13);
        accept();

        tick();
        chk("sb_instr_empty", exp_q.size(), 0);
        chk("sb_addr_empty", addr_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
